// File: rtl/c1o_mem_writer.sv
// ---------------------------------------------------------------------------
// c1o_mem_writer
//   Write-side address generator for the Convolution 1 output memory.
//   The conv engine delivers results channel-interleaved (all CHANNELS words
//   of pixel (r,c) back to back, pixels in raster order). This block stores
//   each word channel-planar at ch*ROWS*COLS + r*COLS + c, so the pooling
//   stage can read every channel plane contiguously.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      one-cycle pulse, begins a new frame (ignored while running)
//   in_valid   in_data carries a conv result
//   in_data    conv result word
//   in_ready   block accepts in_data this cycle (high in RUN)
//   mem_we     write enable to the C1 output RAM (one cycle after accept)
//   mem_addr   write address (holds its last value when mem_we is low)
//   mem_wdata  write data    (holds its last value when mem_we is low)
//   busy       high while a frame is being written
//   done       frame fully written; held until the next start
// ---------------------------------------------------------------------------
module c1o_mem_writer #(
  parameter int DATA_W   = 16,
  parameter int ROWS     = 24,
  parameter int COLS     = 24,
  parameter int CHANNELS = 6,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int COL_W = (COLS > 1)     ? $clog2(COLS)     : 1;
  localparam int ROW_W = (ROWS > 1)     ? $clog2(ROWS)     : 1;

  localparam logic [ADDR_W-1:0] PLANE    = ADDR_W'(ROWS * COLS);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CH_W-1:0]   ch;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] pix_base;   // r*COLS + c of the current pixel
  logic [ADDR_W-1:0] ch_off;     // ch*PLANE of the current element

  logic accept;
  logic ch_wrap;
  logic last_elem;
  logic frame_start;

  // Handshake and terminal detection.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    accept      = in_ready & in_valid;
    ch_wrap     = (ch == CH_LAST);
    last_elem   = ch_wrap && (col == COL_LAST) && (row == ROW_LAST);
    // start is honoured only outside RUN; in_ready is low then, so a
    // simultaneous in_valid is never accepted on a start cycle.
    frame_start = start && (state != S_RUN);
  end

  // --- FSM: state register -------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, matching the hardware regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // --- FSM: next-state logic -----------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start)               state_nxt = S_RUN;
      S_RUN:   if (accept && last_elem) state_nxt = S_DONE;
      S_DONE:  if (start)               state_nxt = S_RUN;
      default:                          state_nxt = S_IDLE;
    endcase
  end

  // --- FSM: outputs decoded from state -------------------------------------
  always_comb begin
    in_ready = (state == S_RUN);
    busy     = (state == S_RUN);
    done     = (state == S_DONE);
  end

  // --- Element counters and incremental address terms ----------------------
  // ch_off walks the channel planes for one pixel; pix_base advances once per
  // pixel. row/col only exist to recognise the last pixel of the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch       <= '0;
      col      <= '0;
      row      <= '0;
      pix_base <= '0;
      ch_off   <= '0;
    end else if (frame_start) begin
      ch       <= '0;
      col      <= '0;
      row      <= '0;
      pix_base <= '0;
      ch_off   <= '0;
    end else if (accept) begin
      if (ch_wrap) begin
        ch       <= '0;
        ch_off   <= '0;
        pix_base <= pix_base + ADDR_W'(1);
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end else begin
        ch     <= ch + CH_W'(1);
        ch_off <= ch_off + PLANE;
      end
    end
  end

  // --- Registered memory write port ----------------------------------------
  // NOTE: these are plain registers, not a RAM array, so they take the async
  // reset; asserting reset kills a pending mem_we immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= pix_base + ch_off;
        mem_wdata <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_c1o_mem_writer.sv
module tb_c1o_mem_writer;

  localparam int ROWS     = 24;
  localparam int COLS     = 24;
  localparam int CHANNELS = 6;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 16;
  localparam int PLANE    = ROWS * COLS;
  localparam int TOTAL    = PLANE * CHANNELS;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;

  c1o_mem_writer #(
    .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS),
    .CHANNELS(CHANNELS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total_checks = 0;
  int bad_checks   = 0;

  // Behavioural model: frame progress is just "how many elements accepted".
  int                m_state;   // 0 idle, 1 running, 2 finished
  int                m_k;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  int mem_val[TOTAL];
  int mem_cnt[TOTAL];
  bit rec = 1'b0;

  typedef struct {
    bit          s;
    bit          v;
    logic [15:0] d;
    bit          we;
    int          addr;
    logic [15:0] wd;
    bit          busy;
    bit          done;
  } vec_t;

  vec_t vecs[10];

  // Element k belongs to pixel k/CHANNELS and channel k%CHANNELS.
  function automatic int addr_of(input int k);
    return (k % CHANNELS) * PLANE + k / CHANNELS;
  endfunction

  function automatic logic [31:0] obs();
    return {in_ready, busy, done, mem_we, mem_addr, mem_wdata};
  endfunction

  function automatic logic [31:0] expv();
    return {m_state == 1, m_state == 1, m_state == 2, m_we, m_addr, m_wdata};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      bad_checks++;
      $display("FAIL %s: got %h expected %h (t=%0t, k=%0d)", name, act, exp, $time, m_k);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_k     = 0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
  endtask

  task automatic model_step(input bit s, input bit v, input logic [15:0] d);
    bit was_run;
    was_run = (m_state == 1);
    if (was_run && v) begin
      m_we    = 1'b1;
      m_addr  = ADDR_W'(addr_of(m_k));
      m_wdata = d;
      m_k++;
      if (m_k == TOTAL) m_state = 2;
    end else begin
      m_we = 1'b0;
    end
    if (!was_run && s) begin
      m_state = 1;
      m_k     = 0;
    end
  endtask

  task automatic step(input bit s, input bit v, input logic [15:0] d, input string name);
    start    = s;
    in_valid = v;
    in_data  = d;
    model_step(s, v, d);
    @(posedge clk);
    #1;
    check(name, obs(), expv());
    if (rec && mem_we && (int'(mem_addr) < TOTAL)) begin
      mem_cnt[mem_addr]++;
      mem_val[mem_addr] = int'(mem_wdata);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    #1 check(name, obs(), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          gapped;
    bit          v;
    bit          s;
    int          errs;
    int          a;
    logic [15:0] want;

    // {start, in_valid, in_data, we, addr, wdata, busy, done}
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0,    0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0010, 1'b1,    0, 16'h0010, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'h0011, 1'b1,  576, 16'h0011, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'h0012, 1'b1, 1152, 16'h0012, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 16'h0013, 1'b1, 1728, 16'h0013, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'h0014, 1'b1, 2304, 16'h0014, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 16'h0015, 1'b1, 2880, 16'h0015, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 16'hbeef, 1'b0, 2880, 16'h0015, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 16'h0016, 1'b1,    1, 16'h0016, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 16'h0017, 1'b1,  577, 16'h0017, 1'b1, 1'b0};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    model_reset();
    #12 check("reset_state", obs(), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // First pixels of a frame from the table.
    for (int i = 0; i < 10; i++) begin
      start    = vecs[i].s;
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), obs(),
            {vecs[i].busy, vecs[i].busy, vecs[i].done, vecs[i].we,
             ADDR_W'(vecs[i].addr), vecs[i].wd});
    end

    do_reset("reset_after_table");

    // Full frame, data = element index, random in_valid gaps and start pulses.
    foreach (mem_cnt[i]) begin
      mem_cnt[i] = 0;
      mem_val[i] = -1;
    end
    rec = 1'b1;
    step(1'b1, 1'b0, 16'h0, "frame_start");
    gapped = 1'b0;
    while (m_k < TOTAL) begin
      if (m_k == 300 && !gapped) begin
        gapped = 1'b1;
        step(1'b0, 1'b0, 16'hdead, "gap0");
        step(1'b1, 1'b0, 16'hdead, "gap_start");
        step(1'b0, 1'b0, 16'hdead, "gap2");
      end else begin
        v = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 24) == 0);
        step(s, v, 16'(m_k), "frame");
        if (m_we && m_k == 145) check("elem144_addr", {20'd0, mem_addr}, 32'd24);
      end
    end
    check("final_addr", {20'd0, mem_addr}, 32'd3455);
    check("final_flags", {29'd0, done, busy, mem_we}, 32'b101);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0, "done_hold");
    rec = 1'b0;

    errs = 0;
    for (int ad = 0; ad < TOTAL; ad++) begin
      a = (ad % PLANE) * CHANNELS + ad / PLANE;
      if (mem_cnt[ad] != 1 || mem_val[ad] != a) errs++;
    end
    check("mem_image_errors", 32'(errs), 32'd0);

    // Restart from DONE with start and in_valid together.
    step(1'b1, 1'b1, 16'habcd, "done_start_valid");
    check("restart_done_clear", {30'd0, done, mem_we}, 32'd0);
    step(1'b0, 1'b1, 16'h1234, "restart_first");
    check("restart_addr0", {mem_we, 3'd0, mem_addr, mem_wdata}, {1'b1, 3'd0, 12'd0, 16'h1234});

    // Random data to element 100, then reset mid-frame.
    while (m_k < 100) begin
      want = 16'($urandom);
      step(1'b0, 1'($urandom_range(0, 1)), want, "partial");
    end
    #2 reset = 1'b1;
    #1 check("reset_async", obs(), 32'h0);
    @(posedge clk);
    #1 check("reset_hold", obs(), 32'h0);
    @(negedge clk);
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    step(1'b0, 1'b1, 16'h4444, "idle_no_accept");
    step(1'b1, 1'b1, 16'h5555, "post_reset_start");
    step(1'b0, 1'b1, 16'h7777, "post_reset_first");
    check("post_reset_addr0", {mem_we, 3'd0, mem_addr, mem_wdata}, {1'b1, 3'd0, 12'd0, 16'h7777});
    for (int i = 0; i < 20; i++) begin
      want = 16'($urandom);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), want, "post_reset_rand");
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
